nibble_serial_subtractor: RTL and testbench

Bit-sliced multi-word subtractor computing A − B − Bin over WIDTH-bit unsigned operands, one 4-bit nibble per clock, LSB nibble first. It uses a single 4-bit borrow-ripple slice and carries the borrow between cycles in a register. Operands arrive on a valid/ready input port and results leave on a valid/ready output port. It sits in front of wide-operand consumers that need subtraction wider than one 4-bit subtractor, trading latency for area.

---
 rtl/nibble_serial_subtractor.sv | 111 +++++++++++
 tb/tb_nibble_serial_subtractor.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_subtractor.sv
// Serial A - B - Bin: one 4-bit borrow-ripple slice per clock, LSB nibble first.
// state  | meaning
// S_IDLE | waiting for operands (in_ready)
// S_RUN  | subtracting nibble r_idx
// S_DONE | result held until out_ready
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDXW-1:0]  r_idx;
    logic             r_brw;
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [WIDTH-1:0] r_rdiff;

    logic [WIDTH-1:0] w_ra_sh;
    logic [WIDTH-1:0] w_rb_sh;
    logic [3:0]       w_na;
    logic [3:0]       w_nb;
    logic [3:0]       w_d;
    logic [4:0]       w_bb;
    logic             w_last;

    assign w_ra_sh = r_ra >> {r_idx, 2'b00};
    assign w_rb_sh = r_rb >> {r_idx, 2'b00};
    assign w_na    = w_ra_sh[3:0];
    assign w_nb    = w_rb_sh[3:0];
    assign w_last  = (r_idx == LAST_IDX);

    always_comb begin
        w_d     = '0;
        w_bb    = '0;
        w_bb[0] = r_brw;
        for (int i = 0; i < 4; i++) begin
            w_d[i]    = w_na[i] ^ w_nb[i] ^ w_bb[i];
            w_bb[i+1] = (~w_na[i] & w_nb[i]) | (w_nb[i] & w_bb[i]) | (~w_na[i] & w_bb[i]);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_brw   <= 1'b0;
            r_ra    <= '0;
            r_rb    <= '0;
            r_rdiff <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_ra  <= a;
                        r_rb  <= b;
                        r_brw <= bin;
                        r_idx <= '0;
                    end
                end
                S_RUN: begin
                    for (int k = 0; k < NIB; k++) begin
                        if (r_idx == IDXW'(k)) r_rdiff[4*k +: 4] <= w_d;
                    end
                    r_brw <= w_bb[4];
                    if (!w_last) r_idx <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign diff      = r_rdiff;
    assign bout      = r_brw;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Bench for nibble_serial_subtractor at WIDTH 4, 16 and 32 against an arithmetic model.
module tb_nibble_serial_subtractor;
    bit clk = 0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    bit          chk_en = 0;
    logic [31:0] s_a[3];
    logic [31:0] s_b[3];
    logic [31:0] s_diff[3];
    logic        s_bin[3];
    logic        s_iv[3];
    logic        s_or[3];
    logic        s_ir[3];
    logic        s_ov[3];
    logic        s_bout[3];
    bit          s_b2b[3];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int W = (g == 0) ? 4 : (g == 1) ? 16 : 32;
        localparam int N = W / 4;
        localparam longint MASK = (longint'(1) << W) - 1;

        logic [W-1:0] w_diff;
        logic         w_ir;
        logic         w_ov;
        logic         w_bout;

        nibble_serial_subtractor #(.WIDTH(W)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (s_iv[g]),
            .in_ready (w_ir),
            .a        (s_a[g][W-1:0]),
            .b        (s_b[g][W-1:0]),
            .bin      (s_bin[g]),
            .out_valid(w_ov),
            .out_ready(s_or[g]),
            .diff     (w_diff),
            .bout     (w_bout)
        );

        assign s_diff[g] = 32'(w_diff);
        assign s_ir[g]   = w_ir;
        assign s_ov[g]   = w_ov;
        assign s_bout[g] = w_bout;

        // Model: busy for N cycles after an accept, then the result is held until out_ready.
        int          m_busy = 0;
        bit          m_done = 0;
        bit          m_have = 0;
        longint      m_cyc = 0;
        longint      m_acc = 0;
        longint      ma, mb, mbi;
        logic [31:0] m_d = '0;
        logic        m_b = 1'b0;

        always @(posedge clk) begin
            m_cyc++;
            if (!rst_n) begin
                m_busy = 0;
                m_done = 0;
                m_have = 0;
            end else if (m_done) begin
                if (s_or[g]) m_done = 0;
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) m_done = 1;
            end else if (s_iv[g]) begin
                ma  = longint'(s_a[g]) & MASK;
                mb  = longint'(s_b[g]) & MASK;
                mbi = s_bin[g] ? 1 : 0;
                m_d = 32'((ma - mb - mbi) & MASK);
                m_b = (ma < mb + mbi);
                m_busy = N;
                if (s_b2b[g]) begin
                    if (m_have) chk($sformatf("w%0d_issue_interval", W), 32'(m_cyc - m_acc), 32'(N + 2));
                    m_have = 1;
                end else begin
                    m_have = 0;
                end
                m_acc = m_cyc;
            end
        end

        always @(negedge clk) begin
            if (chk_en) begin
                chk($sformatf("w%0d_in_ready", W), 32'(s_ir[g]), 32'(m_busy == 0 && !m_done));
                chk($sformatf("w%0d_out_valid", W), 32'(s_ov[g]), 32'(m_done));
                if (m_done) begin
                    chk($sformatf("w%0d_diff", W), s_diff[g], m_d);
                    chk($sformatf("w%0d_bout", W), 32'(s_bout[g]), 32'(m_b));
                end
            end
        end
    end

    task automatic issue(input int g, input logic [31:0] av, input logic [31:0] bv, input logic bi);
        int t = 0;
        @(negedge clk);
        while (!s_ir[g] && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("issue_ready", 32'(s_ir[g]), 32'd1);
        s_a[g]   = av;
        s_b[g]   = bv;
        s_bin[g] = bi;
        s_iv[g]  = 1'b1;
        @(negedge clk);
        s_iv[g]  = 1'b0;
        s_a[g]   = $urandom;
        s_b[g]   = $urandom;
        s_bin[g] = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_ov(input int g);
        int t = 0;
        while (!s_ov[g] && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("out_valid_seen", 32'(s_ov[g]), 32'd1);
    endtask

    task automatic directed(input int g, input logic [31:0] av, input logic [31:0] bv, input logic bi,
                            input logic [31:0] ed, input logic eb, input int elat, input string nm);
        int lat = 0;
        s_or[g] = 1'b0;
        issue(g, av, bv, bi);
        do begin
            @(negedge clk);
            lat++;
        end while (!s_ov[g] && lat < 50);
        chk({nm, "_latency"}, 32'(lat), 32'(elat));
        chk({nm, "_diff"}, s_diff[g], ed);
        chk({nm, "_bout"}, 32'(s_bout[g]), 32'(eb));
        s_or[g] = 1'b1;
        @(negedge clk);
        s_or[g] = 1'b0;
        chk({nm, "_in_ready_after"}, 32'(s_ir[g]), 32'd1);
    endtask

    task automatic rand_run(input int g, input int n);
        s_or[g] = 1'b1;
        for (int i = 0; i < n; i++) begin
            issue(g, $urandom, $urandom, 1'($urandom_range(0, 1)));
            wait_ov(g);
        end
        @(negedge clk);
        s_or[g] = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            s_a[i] = '0; s_b[i] = '0; s_bin[i] = 1'b0;
            s_iv[i] = 1'b0; s_or[i] = 1'b0; s_b2b[i] = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 32'(s_ir[1]), 32'd1);
        chk("reset_out_valid", 32'(s_ov[1]), 32'd0);
        chk("reset_diff", s_diff[1], 32'h0);
        chk("reset_bout", 32'(s_bout[1]), 32'd0);
        rst_n = 1'b1;
        chk_en = 1;

        directed(1, 32'h1234, 32'h0234, 1'b0, 32'h1000, 1'b0, 4, "w16_1234m0234");
        directed(1, 32'h0000, 32'h0001, 1'b0, 32'hFFFF, 1'b1, 4, "w16_0m1");
        directed(1, 32'hFFFF, 32'hFFFF, 1'b1, 32'hFFFF, 1'b1, 4, "w16_ffff_bin");
        directed(1, 32'h8000, 32'h7FFF, 1'b0, 32'h0001, 1'b0, 4, "w16_borrow_chain");
        directed(0, 32'h3, 32'h5, 1'b1, 32'hD, 1'b1, 1, "w4_3m5m1");
        directed(2, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 8, "w32_0m1");

        // Backpressure: result held for 6 cycles, a stray in_valid is ignored.
        s_or[1] = 1'b0;
        issue(1, 32'h1234, 32'h0234, 1'b0);
        wait_ov(1);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                s_a[1] = 32'hFFFF; s_b[1] = 32'h0001; s_bin[1] = 1'b1; s_iv[1] = 1'b1;
            end else begin
                s_iv[1] = 1'b0;
            end
            @(negedge clk);
            chk("bp_out_valid", 32'(s_ov[1]), 32'd1);
            chk("bp_in_ready", 32'(s_ir[1]), 32'd0);
            chk("bp_diff", s_diff[1], 32'h1000);
            chk("bp_bout", 32'(s_bout[1]), 32'd0);
        end
        s_iv[1] = 1'b0;
        s_or[1] = 1'b1;
        @(negedge clk);
        s_or[1] = 1'b0;
        chk("bp_release_in_ready", 32'(s_ir[1]), 32'd1);
        repeat (8) @(negedge clk);
        chk("bp_no_capture", 32'(s_ov[1]), 32'd0);

        // Reset at the second RUN edge discards the operation.
        issue(1, 32'hABCD, 32'h1111, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_run_in_ready", 32'(s_ir[1]), 32'd1);
        chk("rst_run_out_valid", 32'(s_ov[1]), 32'd0);
        chk("rst_run_diff", s_diff[1], 32'h0);
        chk("rst_run_bout", 32'(s_bout[1]), 32'd0);
        repeat (10) @(negedge clk);
        chk("rst_run_no_result", 32'(s_ov[1]), 32'd0);
        directed(1, 32'hABCD, 32'h1111, 1'b1, 32'h9ABB, 1'b0, 4, "w16_after_reset");

        // Back-to-back with in_valid and out_ready tied high.
        s_b2b[1] = 1;
        s_or[1]  = 1'b1;
        s_iv[1]  = 1'b1;
        for (int i = 0; i < 60; i++) begin
            s_a[1]   = $urandom;
            s_b[1]   = $urandom;
            s_bin[1] = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        s_iv[1] = 1'b0;
        repeat (10) @(negedge clk);
        s_b2b[1] = 0;
        s_or[1]  = 1'b0;

        fork
            rand_run(0, 1000);
            rand_run(1, 3000);
            rand_run(2, 3000);
        join

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
